// File: rtl/axi4lite_regbus_bridge.sv
// AXI4-Lite slave that turns each AXI read or write into one held request on
// the register-map bus. Each channel has a one-deep holding register. Reads and
// writes are arbitrated fairly. Addresses outside the decode window get DECERR,
// and a request that never completes is ended with SLVERR after a timeout.
module axi4lite_regbus_bridge #(
  parameter int unsigned      DATA_WIDTH     = 32,
  parameter int unsigned      ADDR_WIDTH     = 32,
  parameter longint unsigned  ADDR_BASE      = 0,
  parameter longint unsigned  ADDR_SPAN      = 4096,
  parameter int unsigned      TIMEOUT_CYCLES = 255,
  localparam int unsigned     STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  bus_req,
  output logic                  bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic [DATA_WIDTH-1:0] bus_wr_biten,
  input  logic                  bus_req_stall_wr,
  input  logic                  bus_req_stall_rd,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic                  bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Decode bounds are one bit wider than the address so BASE+SPAN cannot wrap.
  localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(ADDR_BASE);
  localparam logic [ADDR_WIDTH:0] RANGE_HI = (ADDR_WIDTH+1)'(ADDR_BASE + ADDR_SPAN);

  logic [1:0]            state;
  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  gnt_wr, last_wr;
  logic [1:0]            resp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [31:0]           tmo_cnt;

  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                  wr_pend, rd_pend, grant_any, pick_wr, in_range, timed_out;
  logic [ADDR_WIDTH-1:0] pick_addr;

  assign AWREADY = !aw_full && !ARESET;
  assign WREADY  = !w_full  && !ARESET;
  assign ARREADY = !ar_full && !ARESET;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign b_hs  = BVALID  && BREADY;
  assign r_hs  = RVALID  && RREADY;

  assign wr_pend   = aw_full && w_full && !bus_req_stall_wr;
  assign rd_pend   = ar_full && !bus_req_stall_rd;
  assign grant_any = wr_pend || rd_pend;
  // On a tie the channel that did not win last time is served.
  assign pick_wr   = wr_pend && (!rd_pend || !last_wr);
  assign pick_addr = pick_wr ? aw_addr : ar_addr;
  assign in_range  = ({1'b0, pick_addr} >= RANGE_LO) && ({1'b0, pick_addr} < RANGE_HI);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES));

  assign bus_req       = (state == S_REQ);
  assign bus_req_is_wr = bus_req && gnt_wr;
  assign bus_addr      = gnt_wr ? aw_addr : ar_addr;
  assign bus_wr_data   = w_data;

  assign BVALID = (state == S_RESP) && gnt_wr;
  assign RVALID = (state == S_RESP) && !gnt_wr;
  assign BRESP  = resp;
  assign RRESP  = resp;
  assign RDATA  = rdata;

  // Expand each byte strobe of the held write into eight bit enables.
  always_comb begin
    bus_wr_biten = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      bus_wr_biten[i*8 +: 8] = {8{w_strb[i]}};
    end
  end

  // Per-channel holding registers: filled on the handshake, freed by the response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end else if (b_hs) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end else if (b_hs) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= ARADDR;
      end else if (r_hs) begin
        ar_full <= 1'b0;
      end
    end
  end

  // Arbitrate, decode, hold the bus request and present the AXI response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= S_IDLE;
      gnt_wr  <= 1'b0;
      last_wr <= 1'b0;
      resp    <= 2'b00;
      rdata   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (grant_any) begin
            gnt_wr  <= pick_wr;
            last_wr <= pick_wr;
            if (!in_range) begin
              resp  <= 2'b11;
              rdata <= '0;
              state <= S_RESP;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            resp <= bus_err ? 2'b10 : 2'b00;
            if (!gnt_wr) begin
              rdata <= bus_rd_data;
            end
            state <= S_RESP;
          end else if (timed_out) begin
            resp  <= 2'b10;
            rdata <= '0;
            state <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_RESP: begin
          if (b_hs || r_hs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
